// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-type encodings and default frame/buffer sizes.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int TX_BUF_DEPTH    = 8;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_typ_e;

endpackage

// File: rtl/tx_buf_mem.sv
// TX buffer storage: (DATA_WIDTH+1) x DEPTH, synchronous write, asynchronous read.
module tx_buf_mem
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = TX_BUF_DEPTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH:0]   wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH:0]   rdata
);

    // Contents are intentionally not reset; pointers alone define validity.
    logic [DATA_WIDTH:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tx_data_buffer.sv
// First-word-fall-through TX frame buffer between system controller and TX FSM.
module tx_data_buffer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = TX_BUF_DEPTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      WR_EN,
    input  logic [DATA_WIDTH-1:0]     WR_DATA,
    input  logic                      PAR_TYP,
    input  logic                      TX_ACCEPT,
    input  logic                      CLR_OVF,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_PAR_BIT,
    output logic                      TX_DATA_VALID,
    output logic                      FULL,
    output logic                      EMPTY,
    output logic [$clog2(DEPTH):0]    COUNT,
    output logic                      OVERFLOW
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]         wr_ptr, rd_ptr;
    logic                do_push, do_pop, ovf_set;
    logic                wr_par;
    logic [DATA_WIDTH:0] rd_entry;

    // Flags come only from registered pointers, never from WR_EN/TX_ACCEPT.
    assign EMPTY         = (wr_ptr == rd_ptr);
    assign FULL          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign TX_DATA_VALID = ~EMPTY;
    assign COUNT         = wr_ptr - rd_ptr;

    assign do_pop  = TX_ACCEPT & ~EMPTY;
    assign do_push = WR_EN & (~FULL | do_pop);
    assign ovf_set = WR_EN & FULL & ~do_pop;
    assign wr_par  = (^WR_DATA) ^ (PAR_TYP == PAR_ODD);

    tx_buf_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .we    (do_push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({wr_par, WR_DATA}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );

    // Mask the head while empty so stale storage never reaches the serializer.
    assign TX_P_DATA  = EMPTY ? '0   : rd_entry[DATA_WIDTH-1:0];
    assign TX_PAR_BIT = EMPTY ? 1'b0 : rd_entry[DATA_WIDTH];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (ovf_set)
                OVERFLOW <= 1'b1;
            else if (CLR_OVF)
                OVERFLOW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_data_buffer.sv
// Directed self-checking bench for tx_data_buffer (default 8x8 configuration).
module tb_tx_data_buffer;
    import uart_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       WR_EN = 1'b0;
    logic [7:0] WR_DATA = '0;
    logic       PAR_TYP = 1'b0;
    logic       TX_ACCEPT = 1'b0;
    logic       CLR_OVF = 1'b0;
    logic [7:0] TX_P_DATA;
    logic       TX_PAR_BIT, TX_DATA_VALID, FULL, EMPTY, OVERFLOW;
    logic [3:0] COUNT;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    tx_data_buffer dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .PAR_TYP(PAR_TYP),
        .TX_ACCEPT(TX_ACCEPT), .CLR_OVF(CLR_OVF), .TX_P_DATA(TX_P_DATA),
        .TX_PAR_BIT(TX_PAR_BIT), .TX_DATA_VALID(TX_DATA_VALID), .FULL(FULL),
        .EMPTY(EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given inputs; outputs settle by #1 after the edge.
    task automatic step(input logic we, input logic [7:0] wd, input logic pt,
                        input logic acc, input logic clr);
        WR_EN = we; WR_DATA = wd; PAR_TYP = pt; TX_ACCEPT = acc; CLR_OVF = clr;
        @(posedge CLK);
        #1;
        WR_EN = 1'b0; WR_DATA = '0; PAR_TYP = 1'b0; TX_ACCEPT = 1'b0; CLR_OVF = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " count"}, COUNT, 0);
        chk({tag, " empty"}, EMPTY, 1);
        chk({tag, " full"},  FULL, 0);
        chk({tag, " valid"}, TX_DATA_VALID, 0);
        chk({tag, " data"},  TX_P_DATA, 0);
        chk({tag, " par"},   TX_PAR_BIT, 0);
        chk({tag, " ovf"},   OVERFLOW, 0);
    endtask

    initial begin
        #12;
        chk_reset_vals("rst");
        @(negedge CLK); RST = 1'b1;

        // Single push, first edge after reset release
        step(1, 8'hA5, PAR_EVEN, 0, 0);
        chk("single valid", TX_DATA_VALID, 1);
        chk("single data", TX_P_DATA, 8'hA5);
        chk("single par", TX_PAR_BIT, 0);
        chk("single count", COUNT, 1);
        step(0, 0, 0, 1, 0);
        chk("single drained", EMPTY, 1);

        // Order and odd parity
        step(1, 8'h01, PAR_ODD, 0, 0);
        step(1, 8'h03, PAR_ODD, 0, 0);
        step(1, 8'h07, PAR_ODD, 0, 0);
        chk("ord count", COUNT, 3);
        chk("ord d0", TX_P_DATA, 8'h01);
        chk("ord p0", TX_PAR_BIT, 0);
        step(0, 0, 0, 1, 0);
        chk("ord d1", TX_P_DATA, 8'h03);
        chk("ord p1", TX_PAR_BIT, 1);
        step(0, 0, 0, 1, 0);
        chk("ord d2", TX_P_DATA, 8'h07);
        chk("ord p2", TX_PAR_BIT, 0);
        step(0, 0, 0, 1, 0);
        chk("ord empty", EMPTY, 1);
        chk("ord data0", TX_P_DATA, 0);
        chk("ord par0", TX_PAR_BIT, 0);
        step(0, 0, 0, 1, 0);
        chk("pop-empty count", COUNT, 0);
        chk("pop-empty flag", EMPTY, 1);

        // Fill and overflow
        for (int i = 0; i < 9; i++) begin
            step(1, 8'h10 + 8'(i), PAR_EVEN, 0, 0);
            if (i < 8) exp_q.push_back(8'h10 + 8'(i));
            if (i == 7) begin
                chk("fill full", FULL, 1);
                chk("fill ovf0", OVERFLOW, 0);
            end
        end
        chk("ovf set", OVERFLOW, 1);
        chk("ovf count", COUNT, 8);
        chk("ovf head", TX_P_DATA, 8'h10);
        step(1, 8'hEE, PAR_EVEN, 0, 1);
        chk("ovf set-wins", OVERFLOW, 1);
        chk("ovf count2", COUNT, 8);
        step(0, 0, 0, 0, 1);
        chk("ovf cleared", OVERFLOW, 0);

        // Push and pop together while full, then wrap-around
        step(1, 8'h20, PAR_EVEN, 1, 0);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h20);
        chk("fpp count", COUNT, 8);
        chk("fpp full", FULL, 1);
        chk("fpp head", TX_P_DATA, 8'h11);
        chk("fpp ovf", OVERFLOW, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 8'h30 + 8'(i), PAR_EVEN, 1, 0);
            void'(exp_q.pop_front());
            exp_q.push_back(8'h30 + 8'(i));
            chk($sformatf("wrap head%0d", i), TX_P_DATA, exp_q[0]);
            chk($sformatf("wrap count%0d", i), COUNT, 8);
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), TX_P_DATA, exp_q.pop_front());
            step(0, 0, 0, 1, 0);
        end
        chk("drain empty", EMPTY, 1);

        // Push and pop together while empty: no bypass
        step(1, 8'h5A, PAR_EVEN, 1, 0);
        chk("epp count", COUNT, 1);
        chk("epp data", TX_P_DATA, 8'h5A);
        chk("epp par", TX_PAR_BIT, 0);
        step(0, 0, 0, 1, 0);

        // Reset mid-stream with overflow set and COUNT = 5
        for (int i = 0; i < 9; i++) step(1, 8'h40 + 8'(i), PAR_EVEN, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        chk("pre-rst count", COUNT, 5);
        chk("pre-rst ovf", OVERFLOW, 1);
        @(negedge CLK); RST = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge CLK); RST = 1'b1;
        step(1, 8'h3C, PAR_ODD, 0, 0);
        chk("post-rst data", TX_P_DATA, 8'h3C);
        chk("post-rst par", TX_PAR_BIT, 1);
        chk("post-rst count", COUNT, 1);
        step(0, 0, 0, 1, 0);
        chk("post-rst empty", EMPTY, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
